// File: rtl/sdf_delay_ctrl.sv
// Sequencer for one radix-2 single-delay-feedback FFT stage.
// Drives the delay-line FIFO strobes, the butterfly select and the twiddle
// ROM address, tracks the sample index within a frame and drains the delay
// line after the last frame.
module sdf_delay_ctrl #(
    parameter int DELAY      = 16,
    parameter int INDEX      = 4,
    parameter int FRAME_LEN  = 64,
    parameter int FRAME_BITS = 6,
    parameter int TW_STRIDE  = 2,
    parameter int TW_BITS    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic               err_clr,
    output logic               fifo_w_en,
    output logic               fifo_r_en,
    output logic               bf_sel,
    output logic [TW_BITS-1:0] tw_addr,
    output logic               out_valid,
    output logic               busy,
    output logic [INDEX:0]     occupancy,
    output logic [1:0]         err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        TAIL  = 3'd3,
        FLUSH = 3'd4
    } state_t;

    state_t                r_state, w_nstate;
    logic [FRAME_BITS-1:0] r_s, w_ns;
    logic [INDEX-1:0]      r_f, w_nf;
    logic [INDEX:0]        r_occ;
    logic [1:0]            r_err, w_err_set;
    logic                  w_we, w_re, w_bf;
    logic [TW_BITS-1:0]    w_tw;

    // State, sample index, flush index and sticky error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_f     <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_nstate;
            r_s     <= w_ns;
            r_f     <= w_nf;
            r_err   <= (err_clr ? 2'b00 : r_err) | w_err_set;
        end
    end

    // FIFO fill count, saturating at both ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (w_we && !w_re && r_occ != (INDEX+1)'(DELAY)) begin
            r_occ <= r_occ + 1'b1;
        end else if (w_re && !w_we && r_occ != '0) begin
            r_occ <= r_occ - 1'b1;
        end
    end

    // Next-state, index advance, strobes and error set conditions
    always_comb begin
        w_nstate  = r_state;
        w_ns      = r_s;
        w_nf      = r_f;
        w_we      = 1'b0;
        w_re      = 1'b0;
        w_bf      = 1'b0;
        w_tw      = '0;
        w_err_set = '0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (in_sof) begin
                        w_we     = 1'b1;
                        w_ns     = FRAME_BITS'(1);
                        w_nstate = FILL;
                    end else begin
                        w_err_set[0] = 1'b1;
                    end
                end
            end
            FILL: begin
                if (in_valid) begin
                    w_we = 1'b1;
                    if (in_sof) w_err_set[0] = 1'b1;
                    w_ns = r_s + 1'b1;
                    if (r_s == FRAME_BITS'(DELAY-1)) w_nstate = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    w_we = 1'b1;
                    w_re = 1'b1;
                    w_bf = r_s[INDEX];
                    w_tw = TW_BITS'(32'(r_s[INDEX-1:0]) * TW_STRIDE);
                    if (in_sof) w_err_set[0] = 1'b1;
                    if (r_s == FRAME_BITS'(FRAME_LEN-1)) begin
                        w_ns     = '0;
                        w_nstate = TAIL;
                    end else begin
                        w_ns = r_s + 1'b1;
                    end
                end
            end
            TAIL: begin
                if (in_valid && in_sof) begin
                    w_we     = 1'b1;
                    w_re     = 1'b1;
                    w_ns     = FRAME_BITS'(1);
                    w_nstate = RUN;
                end else begin
                    if (in_valid) w_err_set[0] = 1'b1;
                    w_nstate = FLUSH;
                end
            end
            FLUSH: begin
                w_re = 1'b1;
                w_tw = TW_BITS'(32'(r_f) * TW_STRIDE);
                if (in_valid) w_err_set[1] = 1'b1;
                if (r_f == INDEX'(DELAY-1)) begin
                    w_nf     = '0;
                    w_nstate = IDLE;
                end else begin
                    w_nf = r_f + 1'b1;
                end
            end
            default: w_nstate = IDLE;
        endcase
    end

    // Strobes are forced low while reset is asserted, even if a sof arrives
    assign fifo_w_en = w_we & ~rst;
    assign fifo_r_en = w_re & ~rst;
    assign bf_sel    = w_bf & ~rst;
    assign tw_addr   = rst ? '0 : w_tw;
    assign out_valid = fifo_r_en;
    assign busy      = (r_state != IDLE);
    assign occupancy = r_occ;
    assign err       = r_err;

endmodule
